// File: rtl/i2c_ctrl_writer.sv
// Single-transaction I2C controller: START, 7-bit address + W, ACK, one data
// byte, ACK, STOP. Drives open-drain SCL/SDA enables; reports done + nack.
module i2c_ctrl_writer #(
  parameter int CLKDIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       done,
  output logic       nack,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [2:0] state_dbg
);

  // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, including the cycle done is pulsed.

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_ACK1  = 3'd3,
    S_DATA  = 3'd4,
    S_ACK2  = 3'd5,
    S_STOP  = 3'd6
  } state_t;

  state_t          state, state_n;
  logic [DW-1:0]   div_cnt, div_n;
  logic [1:0]      quarter, quarter_n;
  logic [2:0]      bit_cnt, bit_n;
  logic [7:0]      shift, shift_n;
  logic [7:0]      data_q, data_n;
  logic            nack_n, done_n, ready_n, scl_n, sda_n;

  logic accept;
  logic in_cell;
  logic stretch;
  logic tick;

  assign accept  = cmd_valid && cmd_ready;
  // Bit cells and STOP have an SCL-high Q2 that the target may stretch.
  assign in_cell = (state == S_ADDR) || (state == S_ACK1) || (state == S_DATA) ||
                   (state == S_ACK2) || (state == S_STOP);
  assign stretch = in_cell && (quarter == 2'd2) && !scl_i;
  assign tick    = (state != S_IDLE) && !stretch && (div_cnt == DIV_LAST);

  assign state_dbg = state;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      quarter   <= 2'd0;
      bit_cnt   <= 3'd0;
      shift     <= 8'd0;
      data_q    <= 8'd0;
      nack      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
    end else begin
      state     <= state_n;
      div_cnt   <= div_n;
      quarter   <= quarter_n;
      bit_cnt   <= bit_n;
      shift     <= shift_n;
      data_q    <= data_n;
      nack      <= nack_n;
      done      <= done_n;
      cmd_ready <= ready_n;
      scl_oe    <= scl_n;
      sda_oe    <= sda_n;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_n   = state;
    div_n     = div_cnt;
    quarter_n = quarter;
    bit_n     = bit_cnt;
    shift_n   = shift;
    data_n    = data_q;
    nack_n    = nack;
    done_n    = 1'b0;

    if (state == S_IDLE) begin
      if (accept) begin
        state_n   = S_START;
        div_n     = '0;
        quarter_n = 2'd0;
        bit_n     = 3'd7;
        shift_n   = {cmd_addr, 1'b0};
        data_n    = cmd_data;
        nack_n    = 1'b0;
      end
    end else begin
      if (!stretch) begin
        div_n = tick ? '0 : (div_cnt + DW'(1));
      end
      if (tick) begin
        quarter_n = quarter + 2'd1;
        unique case (state)
          S_START: begin
            if (quarter == 2'd1) begin
              state_n   = S_ADDR;
              quarter_n = 2'd0;
              bit_n     = 3'd7;
            end
          end
          S_ADDR, S_DATA: begin
            if (quarter == 2'd3) begin
              shift_n = {shift[6:0], 1'b0};
              if (bit_cnt == 3'd0) begin
                state_n = (state == S_ADDR) ? S_ACK1 : S_ACK2;
              end else begin
                bit_n = bit_cnt - 3'd1;
              end
            end
          end
          S_ACK1: begin
            if (quarter == 2'd3) begin
              nack_n  = sda_i;
              state_n = sda_i ? S_STOP : S_DATA;
              shift_n = data_q;
              bit_n   = 3'd7;
            end
          end
          S_ACK2: begin
            if (quarter == 2'd3) begin
              nack_n  = sda_i;
              state_n = S_STOP;
            end
          end
          S_STOP: begin
            if (quarter == 2'd3) begin
              state_n = S_IDLE;
              done_n  = 1'b1;
            end
          end
          default: begin
            state_n = S_IDLE;
          end
        endcase
      end
    end
  end

  // Pad enables follow the next state so they change on the same edge as it.
  // The bit under transmission only moves at a cell boundary, so SDA changes
  // only on Q0 entry.
  always_comb begin
    scl_n   = 1'b0;
    sda_n   = 1'b0;
    ready_n = (state_n == S_IDLE);
    unique case (state_n)
      S_IDLE: begin
        scl_n = 1'b0;
        sda_n = 1'b0;
      end
      S_START: begin
        scl_n = 1'b0;
        sda_n = 1'b1;
      end
      S_ADDR, S_DATA: begin
        scl_n = ~quarter_n[1];
        sda_n = ~shift_n[7];
      end
      S_ACK1, S_ACK2: begin
        scl_n = ~quarter_n[1];
        sda_n = 1'b0;
      end
      S_STOP: begin
        scl_n = ~quarter_n[1];
        sda_n = (quarter_n != 2'd3);
      end
      default: begin
        scl_n = 1'b0;
        sda_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_ctrl_writer.sv
// Bench for i2c_ctrl_writer: open-drain bus with a bit-level target model that
// decodes bytes, ACKs/NACKs on demand, and can stretch SCL.
module tb_i2c_ctrl_writer;

  localparam int CLKDIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = 7'd0;
  logic [7:0] cmd_data = 8'd0;
  logic       done, nack;
  logic       scl_oe, sda_oe;
  logic [2:0] state_dbg;
  logic       scl_bus, sda_bus;

  // target side controls
  logic tgt_pull = 1'b0;
  logic tgt_hold = 1'b0;
  logic ack_addr = 1'b1;
  logic ack_data = 1'b1;
  int   stretch_len = 0;

  assign scl_bus = ~scl_oe & ~tgt_hold;
  assign sda_bus = ~sda_oe & ~tgt_pull;

  i2c_ctrl_writer #(.CLKDIV(CLKDIV)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .done(done), .nack(nack),
    .scl_i(scl_bus), .sda_i(sda_bus),
    .scl_oe(scl_oe), .sda_oe(sda_oe),
    .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // target model / bus monitor
  logic       scl_prev = 1'b1, sda_prev = 1'b1;
  int         bit_idx = 0, byte_idx = 0, hold_cnt = 0;
  int         start_cnt = 0, stop_cnt = 0;
  logic [7:0] sh = 8'd0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    scl_prev <= scl_bus;
    sda_prev <= sda_bus;
    if (scl_prev && scl_bus && sda_prev && !sda_bus) begin
      start_cnt <= start_cnt + 1;
      bit_idx   <= 0;
      byte_idx  <= 0;
      tgt_pull  <= 1'b0;
    end else if (scl_prev && scl_bus && !sda_prev && sda_bus) begin
      stop_cnt <= stop_cnt + 1;
    end else if (!scl_prev && scl_bus) begin
      if (bit_idx < 8) sh <= {sh[6:0], sda_bus};
      bit_idx <= bit_idx + 1;
    end else if (scl_prev && !scl_bus) begin
      if (bit_idx == 8) begin
        tgt_pull <= (byte_idx == 0) ? ack_addr : ack_data;
      end else if (bit_idx == 9) begin
        tgt_pull <= 1'b0;
        got_q.push_back(sh);
        byte_idx <= byte_idx + 1;
        bit_idx  <= 0;
      end
      // cell carrying data bit 3: hold SCL low once the controller releases it
      if (byte_idx == 1 && bit_idx == 4 && stretch_len > 0) begin
        tgt_hold <= 1'b1;
        hold_cnt <= 0;
      end
    end
    if (tgt_hold && !scl_oe) begin
      hold_cnt <= hold_cnt + 1;
      if (hold_cnt == stretch_len) tgt_hold <= 1'b0;
    end
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bytes(input string name, input int base);
    int n;
    n = exp_q.size();
    check({name, " byte count"}, got_q.size() - base, n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (base + i < got_q.size()) check({name, " byte"}, got_q[base + i], e);
      else check({name, " byte missing"}, 32'd1, 32'd0);
    end
  endtask

  // driver: one command, measured from acceptance edge to the cycle done is high
  task automatic do_txn(input logic [6:0] a, input logic [7:0] d,
                        output int elapsed, output int first_fall,
                        output logic nack_acc, output logic nack_done,
                        output logic ready_done, output logic done_after);
    int t0, n;
    @(negedge clk);
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    t0 = cyc;
    cmd_valid = 1'b0;
    first_fall = -1;
    n = 0;
    @(negedge clk);
    nack_acc = nack;
    while (!done && n < 2000) begin
      if (scl_oe && first_fall < 0) first_fall = cyc - t0;
      @(negedge clk);
      n++;
    end
    if (!done) check("done timeout", 32'd1, 32'd0);
    elapsed    = cyc - t0;
    nack_done  = nack;
    ready_done = cmd_ready;
    @(negedge clk);
    done_after = done;
  endtask

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    logic       ack_a;
    logic       ack_d;
    int         stretch;
    int         exp_cycles;
    logic       exp_nack;
    int         exp_nbytes;
    logic [7:0] exp_b0;
    logic [7:0] exp_b1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int el, ff, base, t0, s0, p0, n;
    logic na, nd, rd, da;

    vecs[0] = '{7'h2A, 8'hA5, 1'b1, 1'b1, 0,  312, 1'b0, 2, 8'h54, 8'hA5};
    vecs[1] = '{7'h7F, 8'h00, 1'b0, 1'b1, 0,  168, 1'b1, 1, 8'hFE, 8'h00};
    vecs[2] = '{7'h15, 8'h00, 1'b1, 1'b0, 0,  312, 1'b1, 2, 8'h2A, 8'h00};
    vecs[3] = '{7'h2A, 8'hA5, 1'b1, 1'b1, 10, 322, 1'b0, 2, 8'h54, 8'hA5};
    vecs[4] = '{7'h00, 8'hFF, 1'b1, 1'b1, 0,  312, 1'b0, 2, 8'h00, 8'hFF};
    vecs[5] = '{7'h55, 8'h3C, 1'b1, 1'b1, 0,  312, 1'b0, 2, 8'hAA, 8'h3C};

    // reset
    repeat (3) @(negedge clk);
    check("reset cmd_ready", cmd_ready, 1);
    check("reset done", done, 0);
    check("reset nack", nack, 0);
    check("reset scl_oe", scl_oe, 0);
    check("reset sda_oe", sda_oe, 0);
    check("reset state", state_dbg, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // table-driven transfers
    for (int i = 0; i < 6; i++) begin
      ack_addr    = vecs[i].ack_a;
      ack_data    = vecs[i].ack_d;
      stretch_len = vecs[i].stretch;
      base = got_q.size();
      s0 = start_cnt;
      p0 = stop_cnt;
      do_txn(vecs[i].addr, vecs[i].data, el, ff, na, nd, rd, da);
      check($sformatf("v%0d latency", i), el, vecs[i].exp_cycles);
      check($sformatf("v%0d first scl low", i), ff, 2 * CLKDIV);
      check($sformatf("v%0d nack after accept", i), na, 0);
      check($sformatf("v%0d nack", i), nd, vecs[i].exp_nack);
      check($sformatf("v%0d ready at done", i), rd, 1);
      check($sformatf("v%0d done one cycle", i), da, 0);
      check($sformatf("v%0d starts", i), start_cnt - s0, 1);
      check($sformatf("v%0d stops", i), stop_cnt - p0, 1);
      exp_q.push_back(vecs[i].exp_b0);
      if (vecs[i].exp_nbytes > 1) exp_q.push_back(vecs[i].exp_b1);
      check_bytes($sformatf("v%0d", i), base);
      stretch_len = 0;
      repeat (2) @(negedge clk);
    end

    // back-to-back with cmd_valid held high
    ack_addr = 1'b1;
    ack_data = 1'b1;
    base = got_q.size();
    s0 = start_cnt;
    p0 = stop_cnt;
    @(negedge clk);
    cmd_addr  = 7'h11;
    cmd_data  = 8'h22;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    n = 0;
    @(negedge clk);
    while (!done && n < 2000) begin @(negedge clk); n++; end
    check("b2b first latency", cyc - t0, 312);
    check("b2b ready at done", cmd_ready, 1);
    check("b2b starts before second", start_cnt - s0, 1);
    check("b2b stops before second", stop_cnt - p0, 1);
    cmd_addr = 7'h33;
    cmd_data = 8'h44;
    @(negedge clk);
    check("b2b accepted after done", cmd_ready, 0);
    check("b2b done low", done, 0);
    t0 = cyc;
    cmd_valid = 1'b0;
    n = 0;
    while (!done && n < 2000) begin @(negedge clk); n++; end
    check("b2b second latency", cyc - t0, 312);
    check("b2b starts", start_cnt - s0, 2);
    check("b2b stops", stop_cnt - p0, 2);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h66);
    exp_q.push_back(8'h44);
    check_bytes("b2b", base);
    repeat (2) @(negedge clk);

    // reset asserted in the middle of DATA
    @(negedge clk);
    cmd_addr  = 7'h2A;
    cmd_data  = 8'hA5;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    cmd_valid = 1'b0;
    while (cyc - t0 < 54 * CLKDIV + 1) @(negedge clk);
    check("pre-reset in DATA", state_dbg, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid reset scl_oe", scl_oe, 0);
    check("mid reset sda_oe", sda_oe, 0);
    check("mid reset cmd_ready", cmd_ready, 1);
    check("mid reset done", done, 0);
    check("mid reset nack", nack, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    base = got_q.size();
    do_txn(7'h3C, 8'h5A, el, ff, na, nd, rd, da);
    check("post reset latency", el, 312);
    check("post reset nack", nd, 0);
    exp_q.push_back(8'h78);
    exp_q.push_back(8'h5A);
    check_bytes("post reset", base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
